// File: rtl/fifo_joiner4.sv
// Four-to-one stream join: one word per lane is held until all four lanes have a word, then the
// concatenation {lane4,lane3,lane2,lane1} moves to a registered output. FIFO_JOINER_SKEW_EN adds skew_max.
module fifo_joiner4 #(
   parameter int DATA_WIDTH = 32,
   parameter int SKEW_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   data_in1,
   input  logic                    data_in1_valid,
   output logic                    data_in1_ready,
   input  logic [DATA_WIDTH-1:0]   data_in2,
   input  logic                    data_in2_valid,
   output logic                    data_in2_ready,
   input  logic [DATA_WIDTH-1:0]   data_in3,
   input  logic                    data_in3_valid,
   output logic                    data_in3_ready,
   input  logic [DATA_WIDTH-1:0]   data_in4,
   input  logic                    data_in4_valid,
   output logic                    data_in4_ready,
   output logic [4*DATA_WIDTH-1:0] data_out,
   output logic                    data_out_valid,
   input  logic                    data_out_ready
`ifdef FIFO_JOINER_SKEW_EN
   ,
   output logic [SKEW_WIDTH-1:0]   skew_max
`endif
);

   if (DATA_WIDTH < 1 || SKEW_WIDTH < 1) begin : g_param_check
      $error("fifo_joiner4: DATA_WIDTH and SKEW_WIDTH must be at least 1");
   end

   logic [3:0]              in_valid;
   logic [3:0]              in_ready;
   logic [3:0]              accept;
   logic [DATA_WIDTH-1:0]   in_data [4];
   logic [3:0]              full_p0;
   logic [DATA_WIDTH-1:0]   lane_buf_p0 [4];
   logic [4*DATA_WIDTH-1:0] out_data_p1;
   logic                    out_vld_p1;
   logic                    all_full;
   logic                    fire;

   assign in_valid   = {data_in4_valid, data_in3_valid, data_in2_valid, data_in1_valid};
   assign in_data[0] = data_in1;
   assign in_data[1] = data_in2;
   assign in_data[2] = data_in3;
   assign in_data[3] = data_in4;

   // A lane with a held word may still accept in the cycle its word leaves for the output stage.
   assign all_full = &full_p0;
   assign fire     = all_full & (~out_vld_p1 | data_out_ready);
   assign in_ready = ~full_p0 | {4{fire}};
   assign accept   = in_valid & in_ready;

   assign data_in1_ready = in_ready[0];
   assign data_in2_ready = in_ready[1];
   assign data_in3_ready = in_ready[2];
   assign data_in4_ready = in_ready[3];

   // Stage p0: per-lane hold registers
   always_ff @(posedge clk) begin
      if (rst) begin
         full_p0 <= '0;
         for (int k = 0; k < 4; k++) lane_buf_p0[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (accept[k]) begin
               full_p0[k]     <= 1'b1;
               lane_buf_p0[k] <= in_data[k];
            end else if (fire) begin
               full_p0[k] <= 1'b0;
            end
         end
      end
   end

   // Stage p1: registered joined word
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_p1 <= '0;
         out_vld_p1  <= 1'b0;
      end else if (fire) begin
         out_data_p1 <= {lane_buf_p0[3], lane_buf_p0[2], lane_buf_p0[1], lane_buf_p0[0]};
         out_vld_p1  <= 1'b1;
      end else if (out_vld_p1 && data_out_ready) begin
         out_vld_p1 <= 1'b0;
      end
   end

   assign data_out       = out_data_p1;
   assign data_out_valid = out_vld_p1;

`ifdef FIFO_JOINER_SKEW_EN
   logic [SKEW_WIDTH-1:0] skew_cnt;

   function automatic logic [SKEW_WIDTH-1:0] sat_inc(input logic [SKEW_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [SKEW_WIDTH-1:0] max_of(input logic [SKEW_WIDTH-1:0] a,
                                                    input logic [SKEW_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Skew counts cycles spent with some, but not all, lanes holding a word.
   always_ff @(posedge clk) begin
      if (rst) begin
         skew_cnt <= '0;
         skew_max <= '0;
      end else if (fire) begin
         skew_max <= max_of(skew_max, skew_cnt);
         skew_cnt <= '0;
      end else if ((|full_p0) && !all_full) begin
         skew_cnt <= sat_inc(skew_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_joiner4.sv
// Bench for fifo_joiner4: directed scenarios plus random traffic checked against a
// count/queue reference model of the join (per-lane word queues, hold and output occupancy).
module tb_fifo_joiner4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   data_in1 = '0, data_in2 = '0, data_in3 = '0, data_in4 = '0;
   logic            data_in1_valid = 1'b0, data_in2_valid = 1'b0;
   logic            data_in3_valid = 1'b0, data_in4_valid = 1'b0;
   logic            data_in1_ready, data_in2_ready, data_in3_ready, data_in4_ready;
   logic [4*DW-1:0] data_out;
   logic            data_out_valid;
   logic            data_out_ready = 1'b0;
`ifdef FIFO_JOINER_SKEW_EN
   logic [7:0]      skew_max;
`endif

   fifo_joiner4 #(.DATA_WIDTH(DW), .SKEW_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .data_in1(data_in1), .data_in1_valid(data_in1_valid), .data_in1_ready(data_in1_ready),
      .data_in2(data_in2), .data_in2_valid(data_in2_valid), .data_in2_ready(data_in2_ready),
      .data_in3(data_in3), .data_in3_valid(data_in3_valid), .data_in3_ready(data_in3_ready),
      .data_in4(data_in4), .data_in4_valid(data_in4_valid), .data_in4_ready(data_in4_ready),
      .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
`ifdef FIFO_JOINER_SKEW_EN
      , .skew_max(skew_max)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] dat [4];
   logic [DW-1:0] q0[$], q1[$], q2[$], q3[$];
   int            hold [4];
   int            out_occ;
   int            emit_cnt, emit_first, emit_last, step_no;
   logic [3:0]    rdy_obs;

   assign rdy_obs = {data_in4_ready, data_in3_ready, data_in2_ready, data_in1_ready};

   task automatic check_val(input string tag, input logic [4*DW-1:0] got, input logic [4*DW-1:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [4*DW-1:0] front_word();
      return {q3[0], q2[0], q1[0], q0[0]};
   endfunction

   task automatic push_lane(input int k, input logic [DW-1:0] w);
      case (k)
         0: q0.push_back(w);
         1: q1.push_back(w);
         2: q2.push_back(w);
         default: q3.push_back(w);
      endcase
   endtask

   task automatic model_clear();
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      for (int k = 0; k < 4; k++) hold[k] = 0;
      out_occ  = 0;
      emit_cnt = 0;
      step_no  = 0;
   endtask

   // One clock cycle: check outputs against the model, drive inputs, check readies, advance model.
   task automatic step(input logic [3:0] v, input logic sr);
      logic [3:0] rdy_exp;
      bit all_h, mfire, emit;
      @(negedge clk);
      check_val("out_valid", data_out_valid, out_occ != 0);
      if (out_occ != 0) check_val("data_out", data_out, front_word());
      data_in1 = dat[0]; data_in2 = dat[1]; data_in3 = dat[2]; data_in4 = dat[3];
      {data_in4_valid, data_in3_valid, data_in2_valid, data_in1_valid} = v;
      data_out_ready = sr;
      #1;
      all_h = (hold[0] == 1) && (hold[1] == 1) && (hold[2] == 1) && (hold[3] == 1);
      mfire = all_h && (out_occ == 0 || sr);
      for (int k = 0; k < 4; k++) rdy_exp[k] = (hold[k] == 0) || mfire;
      check_val("in_ready", rdy_obs, rdy_exp);
      emit = (out_occ != 0) && sr;
      if (emit) begin
         void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front()); void'(q3.pop_front());
         out_occ = 0;
         emit_cnt++;
         if (emit_cnt == 1) emit_first = step_no;
         emit_last = step_no;
      end
      if (mfire) begin
         for (int k = 0; k < 4; k++) hold[k] = 0;
         out_occ = 1;
      end
      for (int k = 0; k < 4; k++) begin
         if (v[k] && rdy_exp[k]) begin
            push_lane(k, dat[k]);
            hold[k] = 1;
            dat[k]  = $urandom;
         end
      end
      step_no++;
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      {data_in4_valid, data_in3_valid, data_in2_valid, data_in1_valid} = 4'h0;
      data_out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      check_val("rst_ready", rdy_obs, 4'hF);
      check_val("rst_valid", data_out_valid, 1'b0);
      check_val("rst_data", data_out, '0);
`ifdef FIFO_JOINER_SKEW_EN
      check_val("rst_skew", skew_max, '0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int arrive [4];
      logic [3:0] v;
      for (int k = 0; k < 4; k++) dat[k] = '0;
      model_clear();
      repeat (2) @(posedge clk);
      do_reset();

      // T1 basic join
      dat[0] = 32'h11; dat[1] = 32'h22; dat[2] = 32'h33; dat[3] = 32'h44;
      step(4'hF, 1'b1);
      #2 check_val("t1_lat", data_out_valid, 1'b0);
      step(4'h0, 1'b1);
      #2 check_val("t1_valid", data_out_valid, 1'b1);
      check_val("t1_data", data_out, 128'h00000044_00000033_00000022_00000011);
      step(4'h0, 1'b1);
      #2 check_val("t1_one_cycle", data_out_valid, 1'b0);

      // T2 staggered arrival
      do_reset();
      arrive[0] = 0; arrive[1] = 3; arrive[2] = 5; arrive[3] = 9;
      for (int c = 0; c <= 11; c++) begin
         for (int k = 0; k < 4; k++) v[k] = (arrive[k] == c);
         step(v, 1'b1);
         if (c == 0) #2 check_val("t2_early_rdy", data_in1_ready, 1'b0);
         if (c == 9) #2 check_val("t2_not_yet", data_out_valid, 1'b0);
         if (c == 10) begin
            #2 check_val("t2_valid", data_out_valid, 1'b1);
`ifdef FIFO_JOINER_SKEW_EN
            check_val("t2_skew", skew_max, 8'd9);
`endif
         end
      end

      // T3 backpressure with two words per lane
      do_reset();
      for (int k = 0; k < 4; k++) dat[k] = 32'hA0 + k;
      step(4'hF, 1'b0);
      for (int k = 0; k < 4; k++) dat[k] = 32'hB0 + k;
      step(4'hF, 1'b0);
      repeat (8) step(4'h0, 1'b0);
      #2 check_val("t3_hold", data_out, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      check_val("t3_rdy_low", rdy_obs, 4'h0);
      step(4'h0, 1'b1);
      #2 check_val("t3_second", data_out, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
      repeat (2) step(4'h0, 1'b1);

      // T4 streaming 100 words per lane
      do_reset();
      for (int i = 0; i < 102; i++) step((i < 100) ? 4'hF : 4'h0, 1'b1);
      check_val("t4_count", emit_cnt, 100);
      check_val("t4_first", emit_first, 2);
      check_val("t4_last", emit_last, 101);

      // T5 reset mid-operation
      do_reset();
      step(4'hF, 1'b0);
      step(4'h0, 1'b0);
      step(4'b0101, 1'b0);
      do_reset();
      dat[0] = 32'h55; dat[1] = 32'h66; dat[2] = 32'h77; dat[3] = 32'h88;
      step(4'hF, 1'b1);
      step(4'h0, 1'b1);
      #2 check_val("t5_rejoin", data_out, {32'h88, 32'h77, 32'h66, 32'h55});

      // T6 random traffic
      do_reset();
      for (int i = 0; i < 10000; i++)
         step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      repeat (4) step(4'h0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
